// File: rtl/modmul_pipe.sv
// Three-stage Barrett modular multiplier mod 3329 with a cycle-aligned sideband tag.
// Each stage has its own valid bit, so bubbles collapse when the output is back-pressured.
module modmul_pipe #(
  parameter int unsigned TAG_W     = 12,
  parameter int unsigned Q         = 3329,
  parameter int unsigned BARRETT_M = 5039
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      A,
  input  logic [11:0]      B,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      C,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  logic             s1_valid_q;
  logic [23:0]      s1_p_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             s2_valid_q;
  logic [23:0]      s2_p_q;
  logic [11:0]      s2_t_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic             s3_valid_q;
  logic [11:0]      c_q;
  logic [TAG_W-1:0] tag_q;

  logic        s1_en, s2_en, s3_en;
  logic [23:0] prod;
  logic [11:0] quot;
  logic [13:0] rem0, rem1, rem2;

  // A stage may load when it is empty or its successor takes its entry this cycle.
  always_comb begin
    s3_en = !s3_valid_q || out_ready;
    s2_en = !s2_valid_q || s3_en;
    s1_en = !s1_valid_q || s2_en;
  end

  always_comb begin
    prod = 24'(A) * 24'(B);
    quot = 12'((36'(s1_p_q) * 36'(BARRETT_M)) >> 24);
    // Barrett estimate undershoots by at most 2, so R < 3Q before correction.
    rem0 = 14'(s2_p_q - 24'(s2_t_q) * 24'(Q));
    rem1 = (rem0 >= 14'(Q)) ? rem0 - 14'(Q) : rem0;
    rem2 = (rem1 >= 14'(Q)) ? rem1 - 14'(Q) : rem1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
    end else begin
      if (s1_en) s1_valid_q <= in_valid;
      if (s2_en) s2_valid_q <= s1_valid_q;
      if (s3_en) s3_valid_q <= s2_valid_q;
    end
  end

  // Data of empty stages is don't-care, so only the output register is gated by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p_q   <= '0;
      s1_tag_q <= '0;
      s2_p_q   <= '0;
      s2_t_q   <= '0;
      s2_tag_q <= '0;
      c_q      <= '0;
      tag_q    <= '0;
    end else begin
      if (s1_en) begin
        s1_p_q   <= prod;
        s1_tag_q <= in_tag;
      end
      if (s2_en) begin
        s2_p_q   <= s1_p_q;
        s2_t_q   <= quot;
        s2_tag_q <= s1_tag_q;
      end
      if (s3_en && s2_valid_q) begin
        c_q   <= 12'(rem2);
        tag_q <= s2_tag_q;
      end
    end
  end

  always_comb begin
    in_ready  = s1_en;
    out_valid = s3_valid_q;
    C         = c_q;
    out_tag   = tag_q;
    busy      = s1_valid_q | s2_valid_q | s3_valid_q;
  end

endmodule

// File: tb/tb_modmul_pipe.sv
// Bench for modmul_pipe: queue-based reference of (A*B)%3329 checked on every output transfer,
// plus directed literal results, stall/resume, mid-stream reset and a full A sweep.
module tb_modmul_pipe;
  localparam int unsigned TagW = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic            in_ready, out_valid, busy;
  logic [11:0]     a = '0, b = '0, c;
  logic [TagW-1:0] in_tag = '0, out_tag;

  always #5 clk = ~clk;

  modmul_pipe #(.TAG_W(TagW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a),
    .B        (b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .C        (c),
    .out_tag  (out_tag),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int unsigned     exp_c[$];
  logic [TagW-1:0] exp_tag[$];
  int              acc_cyc[$];
  logic            hold_prev = 1'b0;
  logic [11:0]     prev_c;
  logic [TagW-1:0] prev_tag;
  logic            rand_run;

  function automatic void check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) cycle <= cycle + 1;

  // Sample between edges: these values decide the transfers at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy vs occupancy", busy, exp_c.size() != 0);
      check("occupancy <= 3", exp_c.size() <= 3, 1);
      if (hold_prev && out_valid) begin
        check("stall C stable", c, prev_c);
        check("stall tag stable", out_tag, prev_tag);
      end
      if (out_valid && out_ready) begin
        if (exp_c.size() == 0) begin
          check("unexpected output", 1, 0);
        end else begin
          check("C vs model", c, exp_c.pop_front());
          check("tag vs model", out_tag, exp_tag.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_c.push_back((int'(a) * int'(b)) % 3329);
        exp_tag.push_back(in_tag);
        acc_cyc.push_back(cycle);
      end
      hold_prev = out_valid && !out_ready;
      prev_c    = c;
      prev_tag  = out_tag;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic send(input logic [11:0] x, input logic [11:0] y, input logic [TagW-1:0] t);
    int k = 0;
    a = x;
    b = y;
    in_tag = t;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("send timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    @(negedge clk);
    while (busy && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("drain busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  // Expects an empty pipeline and out_ready=1.
  task automatic directed(input logic [11:0] x, input logic [11:0] y, input logic [TagW-1:0] t,
                          input int unsigned expc, input string name);
    int n = 0;
    send(x, y, t);
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check({name, " latency"}, n, 3);
    check({name, " C"}, c, expc);
    check({name, " tag"}, out_tag, t);
    wait_drain();
  endtask

  initial begin
    int rel;
    #3;
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset C", c, 0);
    check("reset out_tag", out_tag, 0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    directed(12'd3328, 12'd3328, 12'hABC, 1, "max*max");
    directed(12'd1000, 12'd1000, 12'h001, 1300, "1000*1000");
    directed(12'd2, 12'd1665, 12'h002, 1, "2*1665");
    directed(12'd0, 12'd3000, 12'h003, 0, "0*3000");

    // Back-to-back random stream at full throughput.
    acc_cyc.delete();
    for (int i = 0; i < 100; i++)
      send(12'($urandom_range(0, 3328)), 12'($urandom_range(0, 3328)), 12'($urandom));
    wait_drain();
    if (acc_cyc.size() == 100) check("b2b throughput", acc_cyc[99] - acc_cyc[0], 99);
    else check("b2b accepts", acc_cyc.size(), 100);

    // Stall with 5 offered inputs, then release.
    out_ready = 1'b0;
    acc_cyc.delete();
    rel = 0;
    fork
      for (int i = 0; i < 5; i++)
        send(12'($urandom_range(0, 3328)), 12'($urandom_range(0, 3328)), 12'(16'h100 + i));
      begin
        repeat (10) @(posedge clk);
        #1;
        check("stall accepted", acc_cyc.size(), 3);
        check("stall in_ready", in_ready, 0);
        check("stall out_valid", out_valid, 1);
        rel = cycle;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    if (acc_cyc.size() == 5) begin
      check("resume 4th no gap", acc_cyc[3], rel);
      check("resume 5th no gap", acc_cyc[4], rel + 1);
    end else begin
      check("stall total accepts", acc_cyc.size(), 5);
    end

    // Random input gaps with random back-pressure.
    rand_run = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(12'($urandom_range(0, 3328)), 12'($urandom_range(0, 3328)), 12'($urandom));
        end
        rand_run = 1'b0;
      end
      begin
        while (rand_run) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with two entries in flight.
    send(12'd100, 12'd200, 12'h0EE);
    send(12'd300, 12'd400, 12'h0EF);
    #2;
    rst_n = 1'b0;
    exp_c.delete();
    exp_tag.delete();
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    directed(12'd7, 12'd9, 12'h079, 63, "post-reset 7*9");

    // Exhaustive A sweep against B=3328.
    for (int i = 0; i < 3329; i++) send(12'(i), 12'd3328, 12'(i));
    wait_drain();
    check("model empty at end", exp_c.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule
